hdmi_slip_align: RTL
====================

# hdmi_slip_align

Word-alignment controller for one TMDS channel of the HDMI receiver. It watches the 10-bit word output by the pixel-slip stage and recognises runs of TMDS control tokens, which occur during blanking. It drives that stage's slip amount, stepping through the ten possible bit offsets until a valid token run is found. Once a run is found it holds lock, and it re-enters the search if tokens stop appearing.

## Interface
- `THRESH`, default 12: number of consecutive control tokens that qualifies a run. Range 2..255.
- `WINDOW`, default 4096: maximum number of evaluated pixels allowed without a qualifying run before the slip advances. Power of two, at least 16.
- `SETTLE`, default 4: cycles to ignore after each slip change, covering the slip-stage pipeline latency. Range 1..15.
- `i_clk`  in  1: pixel clock; all logic is on its rising edge.
- `i_reset`  in  1: reset, asynchronous and active-high.
- `i_pixel`  in  10: aligned word from the slip stage.
- `o_slip`  out  5: slip amount sent to the slip stage, always within 0..9.
- `o_locked`  out  1: high while alignment is held.
- `o_adv`  out  1: one-cycle pulse on every slip advance.

## Operation
- Token hit (combinational): `i_pixel` is one of 10'h354, 10'h0AB, 10'h154 or 10'h2AB.
- Run counter, 8 bits:
  - increments on a hit and saturates at `THRESH`;
  - clears to 0 on a miss;
  - is held at 0 while in SETTLE.
- Run-complete event, `run_ok`: a hit in a cycle where the run counter equals `THRESH`-1. This requires exactly `THRESH` consecutive hits.
- Window counter, log2(`WINDOW`) bits: counts evaluated cycles in SEARCH and LOCKED. Expiry is the cycle in which it equals `WINDOW`-1.
- State machine:
  - **SETTLE:** the settle counter loads `SETTLE`-1 on entry and counts down. At 0, go to SEARCH, with the window and run counters at 0.
  - **SEARCH:**
    - on `run_ok`, go to LOCKED, set `o_locked`=1 and clear the window counter;
    - otherwise, on expiry, advance the slip and go to SETTLE.
  - **LOCKED:**
    - on `run_ok`, clear the window counter;
    - otherwise, on expiry, set `o_locked`=0, advance the slip and go to SETTLE.
- Slip advance: `o_slip` becomes (`o_slip`==9) ? 0 : `o_slip`+1, and `o_adv` pulses for 1 cycle.
- Simultaneous `run_ok` and expiry: `run_ok` wins and no advance occurs.
- A run that spans SEARCH into LOCKED needs no special handling. The run counter keeps saturating and emits further `run_ok` events only after a miss and a fresh run of `THRESH` hits.

## Timing
- Reset values: `o_slip`=0, `o_locked`=0, `o_adv`=0, state SETTLE, settle counter `SETTLE`-1, run and window counters 0.
- Reset asserted mid-operation forces these values immediately, regardless of the clock.
- All outputs are registered.
- Latencies, counted from the clock edge that samples the triggering `i_pixel`:
  - `o_locked` rises 1 cycle after the edge sampling the `THRESH`-th consecutive hit;
  - `o_slip` and `o_adv` update 1 cycle after the edge sampling the expiry cycle.
- After a slip change, `i_pixel` is ignored for exactly `SETTLE` cycles. The first evaluated word is the one sampled `SETTLE`+1 edges after `o_slip` changes.
- With no qualifying run at any offset, the slip period is `WINDOW`+`SETTLE` cycles per offset, and `o_slip` cycles 0,1,…,9,0 with wrap-around.
- A hit immediately following SETTLE counts as hit 1 of a run. Partial runs in progress at an expiry are discarded.

## Test plan
- **Reset value:** assert `i_reset` asynchronously mid-clock → `o_slip`=0 and `o_locked`=0 before the next edge. Deassert → no `o_adv` for `WINDOW`+`SETTLE`-1 cycles.
- **Sweep and lock:**
  - Setup: bench model of the 30-bit slip stage fed with a 10-bit-rotated stream; correct offset is 7; blanking of 20×10'h354 every 200 pixels; `WINDOW`=256.
  - Required: `o_slip` steps 0→7, `o_locked` rises, and `o_slip` then stays at 7 for 10 000 cycles.
- **Threshold boundary:** at lock, 11 hits then a miss → no lock. 12 hits → `o_locked`=1 exactly 1 cycle after the 12th hit is sampled.
- **Loss of lock:**
  - Setup: locked at slip 3; stop tokens.
  - Required: after `WINDOW` evaluated cycles, `o_locked`=0, `o_slip`=4 and `o_adv` is a single pulse.
- **Wrap-around:** token-free stream from reset → `o_slip` sequence 0..9,0, with the 9→0 step exactly `WINDOW`+`SETTLE` cycles after 8→9.
- **Simultaneous events:** time the 12th hit to land on the window-expiry cycle in SEARCH → `o_locked`=1, `o_slip` unchanged, no `o_adv`.

Source files
------------

// File: rtl/hdmi_slip_align_if.sv
// Link between the TMDS word-alignment controller and the pixel-slip stage.
// The master side is the aligner (owns the slip amount); the slave side is the slip stage.
interface hdmi_slip_align_if;
   logic [9:0] i_pixel;
   logic [4:0] o_slip;
   logic       o_locked;
   logic       o_adv;

   modport master (input i_pixel, output o_slip, output o_locked, output o_adv);
   modport slave  (output i_pixel, input o_slip, input o_locked, input o_adv);
endinterface

// File: rtl/hdmi_slip_align.sv
// Word-alignment controller for one TMDS channel: sweeps the slip offset until a run of
// control tokens is seen, then holds lock until tokens stop appearing for a full window.
module hdmi_slip_align #(
   parameter int THRESH = 12,
   parameter int WINDOW = 4096,
   parameter int SETTLE = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   hdmi_slip_align_if.master bus
);
   localparam int WW = $clog2(WINDOW);
   localparam logic [7:0]    RUN_LAST    = 8'(THRESH - 1);
   localparam logic [7:0]    RUN_MAX     = 8'(THRESH);
   localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE - 1);
   localparam logic [WW-1:0] WIN_LAST    = {WW{1'b1}};

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   function automatic logic is_token(input logic [9:0] w);
      logic r;
      case (w)
         10'h354, 10'h0AB, 10'h154, 10'h2AB: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   state_t        state_r;
   logic [3:0]    settle_cnt_r;
   logic [7:0]    run_cnt_r;
   logic [WW-1:0] win_cnt_r;
   logic [4:0]    slip_r;
   logic          locked_r;
   logic          adv_r;

   logic          hit_s;
   logic          run_ok_s;
   logic          expiry_s;
   logic [7:0]    run_next_s;
   logic [4:0]    slip_next_s;

   // Token detection, run-complete / window-expiry events and next-value helpers.
   always_comb begin
      hit_s       = is_token(bus.i_pixel);
      run_ok_s    = (state_r != ST_SETTLE) && hit_s && (run_cnt_r == RUN_LAST);
      expiry_s    = (win_cnt_r == WIN_LAST);
      slip_next_s = (slip_r == 5'd9) ? 5'd0 : slip_r + 5'd1;
      if (!hit_s) begin
         run_next_s = 8'd0;
      end else if (run_cnt_r == RUN_MAX) begin
         run_next_s = run_cnt_r;
      end else begin
         run_next_s = run_cnt_r + 8'd1;
      end
   end

   // Alignment state machine with registered slip/lock/advance outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r      <= ST_SETTLE;
         settle_cnt_r <= SETTLE_LOAD;
         run_cnt_r    <= 8'd0;
         win_cnt_r    <= '0;
         slip_r       <= 5'd0;
         locked_r     <= 1'b0;
         adv_r        <= 1'b0;
      end else begin
         adv_r <= 1'b0;
         case (state_r)
            ST_SETTLE: begin
               run_cnt_r <= 8'd0;
               win_cnt_r <= '0;
               if (settle_cnt_r == 4'd0) begin
                  state_r <= ST_SEARCH;
               end else begin
                  settle_cnt_r <= settle_cnt_r - 4'd1;
               end
            end
            ST_SEARCH: begin
               run_cnt_r <= run_next_s;
               if (run_ok_s) begin
                  state_r   <= ST_LOCKED;
                  locked_r  <= 1'b1;
                  win_cnt_r <= '0;
               end else if (expiry_s) begin
                  state_r      <= ST_SETTLE;
                  settle_cnt_r <= SETTLE_LOAD;
                  slip_r       <= slip_next_s;
                  adv_r        <= 1'b1;
                  run_cnt_r    <= 8'd0;
                  win_cnt_r    <= '0;
               end else begin
                  win_cnt_r <= win_cnt_r + WW'(1);
               end
            end
            ST_LOCKED: begin
               run_cnt_r <= run_next_s;
               if (run_ok_s) begin
                  win_cnt_r <= '0;
               end else if (expiry_s) begin
                  // Tokens have gone quiet for a whole window: drop lock and resume the sweep.
                  state_r      <= ST_SETTLE;
                  settle_cnt_r <= SETTLE_LOAD;
                  locked_r     <= 1'b0;
                  slip_r       <= slip_next_s;
                  adv_r        <= 1'b1;
                  run_cnt_r    <= 8'd0;
                  win_cnt_r    <= '0;
               end else begin
                  win_cnt_r <= win_cnt_r + WW'(1);
               end
            end
            default: begin
               state_r      <= ST_SETTLE;
               settle_cnt_r <= SETTLE_LOAD;
               run_cnt_r    <= 8'd0;
               win_cnt_r    <= '0;
               locked_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_slip   = slip_r;
   assign bus.o_locked = locked_r;
   assign bus.o_adv    = adv_r;
endmodule
